// File: rtl/fetch_redirect_ctrl.sv
// fetch_redirect_ctrl: PC sequencing with branch/jr/j redirect arbitration, pending redirects and sticky halt.
// Optional redirect statistics counter enabled by defining REDIRECT_STATS_EN.
module fetch_redirect_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP = 32'd4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] current_pc,
    input  logic        ihit,
    input  logic        stall,
    input  logic        halt,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        jr_valid,
    input  logic [31:0] jr_target,
    input  logic        j_valid,
    input  logic [31:0] j_target,
    output logic [31:0] next_pc,
    output logic        pc_en,
    output logic        flush_ifid,
    output logic        flush_idex,
`ifdef REDIRECT_STATS_EN
    output logic [31:0] redirect_count,
`endif
    output logic        halted
);
    typedef enum logic [1:0] {RUN, PEND, HALTED} state_t;
    state_t state, state_nx;
    logic [31:0] pend_pc, pend_nx, last_pc, seq_pc, redir_pc, pc_c;
    logic go, redir, en_c, fi_c, fe_c, load;
    assign go = ihit & ~stall;
    assign redir = br_taken | jr_valid | j_valid;
    assign redir_pc = br_taken ? br_target : jr_valid ? jr_target : j_target;
    assign seq_pc = current_pc + PC_STEP;
    always_comb begin
        state_nx = state;
        pend_nx = pend_pc;
        pc_c = last_pc;
        en_c = 1'b0;
        fi_c = 1'b0;
        fe_c = 1'b0;
        load = 1'b0;
        if (state == HALTED) begin
            state_nx = HALTED;
        end else if (halt) begin
            state_nx = HALTED;
            pc_c = (state == PEND) ? pend_pc : seq_pc;
        end else if (state == RUN) begin
            fi_c = redir;
            fe_c = br_taken;
            pc_c = redir ? redir_pc : seq_pc;
            en_c = go;
            load = redir & go;
            if (redir & ~go) begin
                pend_nx = redir_pc;
                state_nx = PEND;
            end
        end else begin
            // a branch is older than the latched jump, so it replaces it; jr/j here are wrong-path
            fi_c = br_taken;
            fe_c = br_taken;
            pc_c = br_taken ? br_target : pend_pc;
            en_c = go;
            load = go;
            if (go) state_nx = RUN;
            else pend_nx = pc_c;
        end
    end
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= RUN;
            pend_pc <= RESET_PC;
            last_pc <= RESET_PC;
        end else begin
            state <= state_nx;
            pend_pc <= pend_nx;
            last_pc <= pc_c;
        end
    end
`ifdef REDIRECT_STATS_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) redirect_count <= 32'd0;
        else if (load && redirect_count != 32'hFFFF_FFFF) redirect_count <= redirect_count + 32'd1;
    end
`endif
    assign next_pc = RST ? RESET_PC : pc_c;
    assign pc_en = ~RST & en_c;
    assign flush_ifid = ~RST & fi_c;
    assign flush_idex = ~RST & fe_c;
    assign halted = (state == HALTED);
endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// tb_fetch_redirect_ctrl: directed checks of fetch_redirect_ctrl (redirect_count checked when REDIRECT_STATS_EN is defined).
module tb_fetch_redirect_ctrl;
    logic CLK = 1'b0, RST = 1'b1;
    logic [31:0] current_pc = '0, br_target = '0, jr_target = '0, j_target = '0;
    logic ihit = 0, stall = 0, halt = 0, br_taken = 0, jr_valid = 0, j_valid = 0;
    logic [31:0] next_pc;
    logic pc_en, flush_ifid, flush_idex, halted;
`ifdef REDIRECT_STATS_EN
    logic [31:0] redirect_count;
`endif
    int checks = 0, errors = 0;

    fetch_redirect_ctrl dut (
        .CLK(CLK), .RST(RST), .current_pc(current_pc), .ihit(ihit), .stall(stall), .halt(halt),
        .br_taken(br_taken), .br_target(br_target), .jr_valid(jr_valid), .jr_target(jr_target),
        .j_valid(j_valid), .j_target(j_target), .next_pc(next_pc), .pc_en(pc_en),
        .flush_ifid(flush_ifid), .flush_idex(flush_idex),
`ifdef REDIRECT_STATS_EN
        .redirect_count(redirect_count),
`endif
        .halted(halted)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic outs(input string tag, input logic [31:0] npc, input logic en, input logic fi, input logic fe, input logic h);
        chk({tag, ".next_pc"}, next_pc, npc);
        chk({tag, ".pc_en"}, {31'd0, pc_en}, {31'd0, en});
        chk({tag, ".flush_ifid"}, {31'd0, flush_ifid}, {31'd0, fi});
        chk({tag, ".flush_idex"}, {31'd0, flush_idex}, {31'd0, fe});
        chk({tag, ".halted"}, {31'd0, halted}, {31'd0, h});
    endtask

    task automatic clr;
        br_taken = 0; jr_valid = 0; j_valid = 0; stall = 0; halt = 0;
    endtask

    initial begin
        @(negedge CLK); #1 outs("reset", 32'h0, 0, 0, 0, 0);
        @(negedge CLK); RST = 0; ihit = 1; current_pc = 32'h0; #1 outs("release", 32'h4, 1, 0, 0, 0);
        @(negedge CLK); current_pc = 32'hFFFF_FFFC; #1 outs("wrap", 32'h0, 1, 0, 0, 0);
        @(negedge CLK); current_pc = 32'h10; stall = 1; #1 outs("stall", 32'h14, 0, 0, 0, 0);
        @(negedge CLK); stall = 0; br_taken = 1; br_target = 32'h100; j_valid = 1; j_target = 32'h200;
        #1 outs("br_over_j", 32'h100, 1, 1, 1, 0);
        @(negedge CLK); br_taken = 0; jr_valid = 1; jr_target = 32'h300; #1 outs("jr_over_j", 32'h300, 1, 1, 0, 0);
        @(negedge CLK); clr(); RST = 1; #1 outs("midrun_rst", 32'h0, 0, 0, 0, 0);
        @(negedge CLK); RST = 0; current_pc = 32'h20; j_valid = 1; j_target = 32'h40; ihit = 0;
        #1 outs("pend1", 32'h40, 0, 1, 0, 0);
        @(negedge CLK); #1 outs("pend2", 32'h40, 0, 0, 0, 0);
        @(negedge CLK); #1 outs("pend3", 32'h40, 0, 0, 0, 0);
        @(negedge CLK); j_valid = 0; ihit = 1; #1 outs("pend_commit", 32'h40, 1, 0, 0, 0);
        @(negedge CLK); current_pc = 32'h40; #1 outs("back_run", 32'h44, 1, 0, 0, 0);
        @(negedge CLK); j_valid = 1; j_target = 32'h40; ihit = 0; #1 outs("ow_j", 32'h40, 0, 1, 0, 0);
        @(negedge CLK); j_valid = 0; br_taken = 1; br_target = 32'h80; #1 outs("ow_br", 32'h80, 0, 1, 1, 0);
        @(negedge CLK); br_taken = 0; ihit = 1; #1 outs("ow_commit", 32'h80, 1, 0, 0, 0);
        @(negedge CLK); j_valid = 1; j_target = 32'h60; ihit = 0; #1 outs("rst_pend_a", 32'h60, 0, 1, 0, 0);
        @(negedge CLK); j_valid = 0; RST = 1; #1 outs("rst_pend_b", 32'h0, 0, 0, 0, 0);
`ifdef REDIRECT_STATS_EN
        chk("count_reset", redirect_count, 32'd0);
`endif
        @(negedge CLK); RST = 0; ihit = 1; current_pc = 32'h8; #1 outs("rst_pend_c", 32'hC, 1, 0, 0, 0);
        @(negedge CLK); j_valid = 1; j_target = 32'h50; #1 outs("pre_halt_j", 32'h50, 1, 1, 0, 0);
        @(negedge CLK); j_valid = 0; halt = 1; br_taken = 1; br_target = 32'h900; current_pc = 32'h50;
        #1 chk("halt_cycle.pc_en", {31'd0, pc_en}, 32'd0);
        chk("halt_cycle.flush_idex", {31'd0, flush_idex}, 32'd0);
        chk("halt_cycle.halted", {31'd0, halted}, 32'd0);
`ifdef REDIRECT_STATS_EN
        chk("count_pre_halt", redirect_count, 32'd1);
`endif
        @(negedge CLK); halt = 0;
        for (int i = 0; i < 12; i++) begin
            br_taken = i[0]; jr_valid = i[1]; j_valid = i[2]; stall = 0; ihit = 1;
            #1;
            chk("halted.halted", {31'd0, halted}, 32'd1);
            chk("halted.pc_en", {31'd0, pc_en}, 32'd0);
            chk("halted.flush", {30'd0, flush_ifid, flush_idex}, 32'd0);
`ifdef REDIRECT_STATS_EN
            chk("halted.count", redirect_count, 32'd1);
`endif
            @(negedge CLK);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fetch_redirect_ctrl.md
Name: fetch_redirect_ctrl

Overview:
- Sequences the program counter register: computes next_pc and the PC write-enable each cycle.
- Arbitrates among sequential fetch (PC+4), branch redirect, jump, and jump-register redirects.
- Latches redirects that arrive while an instruction fetch is outstanding.
- Generates pipeline flushes and a sticky halted state. Sits between the hazard unit, branch resolution in MEM, jump decode in ID, and the PC register.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; also the next_pc reset value.
- PC_STEP, 4, sequential increment in bytes.

Ports:
- CLK  input  1  system clock, rising edge.
- RST  input  1  asynchronous, active-high reset.
- current_pc  input  32  present PC register value.
- ihit  input  1  instruction fetch completes this cycle.
- stall  input  1  hazard-unit stall request; freezes PC.
- halt  input  1  halt instruction reached writeback.
- br_taken  input  1  branch resolved taken in MEM.
- br_target  input  32  branch target.
- jr_valid  input  1  JR in ID.
- jr_target  input  32  register target.
- j_valid  input  1  J/JAL in ID.
- j_target  input  32  jump target.
- next_pc  output  32  value to load into the PC.
- pc_en  output  1  PC write enable.
- flush_ifid  output  1  squash the IF/ID latch.
- flush_idex  output  1  squash the ID/EX latch.
- halted  output  1  sticky halted flag.

Behaviour:
- Reset (async, RST=1):
  - state=RUN, pending target=RESET_PC, pend_src=NONE.
  - Outputs: next_pc=RESET_PC, pc_en=0, flush_*=0, halted=0.
- Redirect priority (oldest first): br_taken > jr_valid > j_valid.
  - The winner's target is the redirect target.
  - br_taken also asserts flush_idex, and flush_ifid in the same cycle.
  - jr/j assert flush_ifid only.
  - Flushes are combinational and asserted in the cycle the redirect is seen, regardless of ihit.
- States:
  - RUN:
    - No redirect: next_pc=current_pc+PC_STEP (32-bit wrap, 0xFFFF_FFFC+4=0); pc_en=ihit & ~stall.
    - Redirect and ihit & ~stall: next_pc=target, pc_en=1, stay RUN.
    - Redirect and (~ihit | stall): latch target into pend_pc, pc_en=0, go PEND.
  - PEND:
    - next_pc=pend_pc; pc_en=ihit & ~stall; on pc_en go RUN.
    - A new br_taken in PEND overwrites pend_pc, because it is older than any latched jump.
    - A jr/j in PEND is ignored, because the wrong-path fetch is already squashed.
  - HALTED:
    - Entered from any state the cycle after halt=1 is sampled.
    - pc_en=0, flush_*=0, halted=1; next_pc holds its last value.
    - Only RST exits.
- halt has priority over all redirects and stall. A simultaneous halt+br_taken goes to HALTED with no PC update.
- stall with no redirect in RUN: pc_en=0, next_pc still shows PC+4, no state change.
- next_pc and pc_en are registered-state dependent but combinational from inputs; latency from redirect to PC load is 0 cycles when ihit & ~stall, else the first cycle both hold.
- Reset asserted mid-PEND discards pend_pc.

Optional Feature:
- REDIRECT_STATS_EN defined:
  - Adds output redirect_count [31:0], reset 0.
  - Increments by 1 on each cycle pc_en=1 with a redirect target loaded (RUN redirect or PEND commit).
  - Saturates at 0xFFFF_FFFF and freezes in HALTED.
- Undefined: no port and no counter logic.

Test Plan:
- Reset: RST pulse mid-run → next_pc=0, pc_en=0, halted=0. Release with ihit=1, current_pc=0 → next_pc=4, pc_en=1.
- Sequential wrap: current_pc=0xFFFF_FFFC, ihit=1 → next_pc=0x0000_0000, pc_en=1.
- Priority: br_taken=1 br_target=0x100, j_valid=1 j_target=0x200, ihit=1 → next_pc=0x100, flush_ifid=1, flush_idex=1.
- Pending redirect: j_valid=1 j_target=0x40, ihit=0 for 3 cycles → pc_en=0, flush_ifid=1 in the first cycle only. Then ihit=1 → next_pc=0x40, pc_en=1, state RUN.
- PEND overwrite: pending j to 0x40, then br_taken to 0x80 while ihit=0 → on ihit next_pc=0x80.
- Halt: halt=1 with br_taken=1, ihit=1 → next cycle halted=1, pc_en=0 for 10+ cycles despite ihit/redirects. With REDIRECT_STATS_EN, redirect_count is unchanged.
